// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 register numbers, exception codes and Status/Cause field layout.
package cp0_pkg;
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;
    localparam logic [4:0] CP0_CONFIG  = 5'd16;

    typedef enum logic [4:0] {
        EXC_INT = 5'd0,
        EXC_SYS = 5'd8,
        EXC_RI  = 5'd10,
        EXC_OV  = 5'd12,
        EXC_TR  = 5'd13
    } exccode_e;

    localparam int ET_SYSCALL = 8;
    localparam int ET_RI      = 9;
    localparam int ET_OVF     = 10;
    localparam int ET_TRAP    = 11;
    localparam int ET_ERET    = 12;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;

    localparam logic [31:0] STATUS_RESET = 32'h1000_0000;
    // IM[15:8], EXL and IE are the only software-writable Status bits
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CONFIG_VAL   = 32'h0000_0000;
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: prescaled Count, Compare and the sticky timer interrupt it raises.
module cp0_timer import cp0_pkg::*; #(
    parameter int COUNT_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_count,
    input  logic        we_compare,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        intimer
);
    localparam int PW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0] r_pre;
    logic [31:0]   r_count;
    logic [31:0]   r_compare;
    logic          r_intimer;
    logic          w_wrap;

    assign w_wrap  = r_pre == PW'(COUNT_DIV - 1);
    assign count   = r_count;
    assign compare = r_compare;
    assign intimer = r_intimer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre     <= '0;
            r_count   <= '0;
            r_compare <= '0;
            r_intimer <= 1'b0;
        end else begin
            r_pre <= (we_count || w_wrap) ? '0 : r_pre + 1'b1;
            if (we_count)
                r_count <= wdata;
            else if (w_wrap)
                r_count <= r_count + 32'd1;
            // a Compare write acknowledges the interrupt and masks a same-cycle match
            if (we_compare) begin
                r_compare <= wdata;
                r_intimer <= 1'b0;
            end else if (r_compare != '0 && r_count == r_compare)
                r_intimer <= 1'b1;
        end
    end
endmodule

// File: rtl/cp0_intc.sv
// cp0_intc: CP0 register file plus exception/interrupt prioritiser and PC redirect.
module cp0_intc import cp0_pkg::*; #(
    parameter int          N_HW_INT   = 6,
    parameter int          TIMER_LINE = 5,
    parameter int          COUNT_DIV  = 1,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
    parameter logic [31:0] PRID       = 32'h0000_0001
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_HW_INT-1:0] int_i,
    input  logic                cp0we,
    input  logic [4:0]          cp0wAddr,
    input  logic [31:0]         cp0wData,
    input  logic [4:0]          cp0rAddr,
    output logic [31:0]         cp0rData,
    input  logic [31:0]         pc_i,
    input  logic [31:0]         excptype_i,
    output logic                excpt_o,
    output logic [31:0]         ejpc_o,
    output logic                intimer_o,
    output logic [31:0]         status_o,
    output logic [31:0]         cause_o,
    output logic [31:0]         epc_o
);
    logic [31:0] r_status;
    logic [31:0] r_epc;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exccode;

    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic [31:0] w_cause;
    logic [31:0] w_epc_byp;
    logic [31:0] w_rdata;
    logic [5:0]  w_hw;
    logic [4:0]  w_code;
    logic        w_intimer;
    logic        w_int_pend;
    logic        w_exc;
    logic        w_eret;
    logic        w_we;
    logic        w_unused;

    assign w_unused = ^{excptype_i[31:13], excptype_i[7:0]};

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .we_count  (w_we && cp0wAddr == CP0_COUNT),
        .we_compare(w_we && cp0wAddr == CP0_COMPARE),
        .wdata     (cp0wData),
        .count     (w_count),
        .compare   (w_compare),
        .intimer   (w_intimer)
    );

    assign w_cause    = {16'h0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'b00};
    assign w_int_pend = r_status[ST_IE] & ~r_status[ST_EXL] & |(w_cause[15:8] & r_status[15:8]);
    assign w_code     = w_int_pend ? EXC_INT :
                        excptype_i[ET_SYSCALL] ? EXC_SYS :
                        excptype_i[ET_RI] ? EXC_RI :
                        excptype_i[ET_OVF] ? EXC_OV : EXC_TR;
    // gated by rst so a held exception request cannot redirect while in reset
    assign w_exc      = ~rst & (w_int_pend | |excptype_i[ET_TRAP:ET_SYSCALL]);
    assign w_eret     = ~rst & ~w_exc & excptype_i[ET_ERET];
    assign w_we       = cp0we & ~w_exc;
    assign w_epc_byp  = (w_we && cp0wAddr == CP0_EPC) ? cp0wData : r_epc;

    assign excpt_o   = w_exc | w_eret;
    assign ejpc_o    = w_exc ? EXC_VECTOR : w_eret ? w_epc_byp : '0;
    assign intimer_o = w_intimer;
    assign status_o  = r_status;
    assign cause_o   = w_cause;
    assign epc_o     = r_epc;
    assign cp0rData  = w_rdata;

    always_comb begin
        w_hw = '0;
        w_hw[N_HW_INT-1:0] = int_i;
        w_hw[TIMER_LINE] = w_hw[TIMER_LINE] | w_intimer;
    end

    always_comb begin
        case (cp0rAddr)
            CP0_COUNT:   w_rdata = w_count;
            CP0_COMPARE: w_rdata = w_compare;
            CP0_STATUS:  w_rdata = r_status;
            CP0_CAUSE:   w_rdata = w_cause;
            CP0_EPC:     w_rdata = r_epc;
            CP0_PRID:    w_rdata = PRID;
            CP0_CONFIG:  w_rdata = CONFIG_VAL;
            default:     w_rdata = '0;
        endcase
        if (w_we && cp0wAddr == cp0rAddr)
            w_rdata = cp0wData;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status  <= STATUS_RESET;
            r_epc     <= '0;
            r_ip_hw   <= '0;
            r_ip_sw   <= '0;
            r_exccode <= '0;
        end else begin
            r_ip_hw <= w_hw;
            if (w_we && cp0wAddr == CP0_STATUS)
                r_status <= (r_status & ~STATUS_WMASK) | (cp0wData & STATUS_WMASK);
            if (w_we && cp0wAddr == CP0_CAUSE)
                r_ip_sw <= cp0wData[9:8];
            if (w_we && cp0wAddr == CP0_EPC)
                r_epc <= cp0wData;
            // nested exceptions keep the EPC of the outermost one
            if (w_exc) begin
                r_status[ST_EXL] <= 1'b1;
                r_exccode        <= w_code;
                if (!r_status[ST_EXL])
                    r_epc <= pc_i;
            end else if (w_eret)
                r_status[ST_EXL] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: directed vector table plus hand sequences for timer, interrupt and reset corners.
module tb_cp0_intc;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  int_i = '0;
    logic        cp0we = 1'b0;
    logic [4:0]  cp0wAddr = '0;
    logic [31:0] cp0wData = '0;
    logic [4:0]  cp0rAddr = '0;
    logic [31:0] pc_i = '0;
    logic [31:0] excptype_i = '0;
    logic [31:0] cp0rData, ejpc_o, status_o, cause_o, epc_o;
    logic        excpt_o, intimer_o;

    logic [31:0] u1_count;
    logic [31:0] unused_ejpc, unused_status, unused_cause, unused_epc;
    logic        unused_excpt, unused_intimer;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    cp0_intc #(.COUNT_DIV(1)) dut (
        .clk(clk), .rst(rst), .int_i(int_i), .cp0we(cp0we), .cp0wAddr(cp0wAddr),
        .cp0wData(cp0wData), .cp0rAddr(cp0rAddr), .cp0rData(cp0rData), .pc_i(pc_i),
        .excptype_i(excptype_i), .excpt_o(excpt_o), .ejpc_o(ejpc_o), .intimer_o(intimer_o),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
    );

    cp0_intc #(.COUNT_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .int_i(6'd0), .cp0we(1'b0), .cp0wAddr(5'd0),
        .cp0wData(32'd0), .cp0rAddr(5'd9), .cp0rData(u1_count), .pc_i(32'd0),
        .excptype_i(32'd0), .excpt_o(unused_excpt), .ejpc_o(unused_ejpc), .intimer_o(unused_intimer),
        .status_o(unused_status), .cause_o(unused_cause), .epc_o(unused_epc)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [31:0] pc;
        logic [4:0]  et;
        logic        x_excpt;
        logic [31:0] x_ejpc;
        logic [31:0] x_rd;
    } vec_t;

    vec_t v[20];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic found;
        // et bits: 0 syscall, 1 RI, 2 ovf, 3 trap, 4 eret
        v[0]  = '{1'b1, 5'd14, 32'h200,       5'd14, 32'h0,   5'b00000, 1'b0, 32'h0,   32'h200};
        v[1]  = '{1'b0, 5'd0,  32'h0,         5'd14, 32'h0,   5'b00000, 1'b0, 32'h0,   32'h200};
        v[2]  = '{1'b0, 5'd0,  32'h0,         5'd12, 32'h100, 5'b00001, 1'b1, 32'h40,  32'h1000_0000};
        v[3]  = '{1'b0, 5'd0,  32'h0,         5'd13, 32'h0,   5'b10000, 1'b1, 32'h100, 32'h20};
        v[4]  = '{1'b0, 5'd0,  32'h0,         5'd12, 32'h0,   5'b00000, 1'b0, 32'h0,   32'h1000_0000};
        v[5]  = '{1'b1, 5'd12, 32'h1000_FF01, 5'd14, 32'h300, 5'b00010, 1'b1, 32'h40,  32'h100};
        v[6]  = '{1'b0, 5'd0,  32'h0,         5'd12, 32'h400, 5'b00100, 1'b1, 32'h40,  32'h1000_0002};
        v[7]  = '{1'b0, 5'd0,  32'h0,         5'd14, 32'h0,   5'b11000, 1'b1, 32'h40,  32'h300};
        v[8]  = '{1'b0, 5'd0,  32'h0,         5'd13, 32'h0,   5'b10000, 1'b1, 32'h300, 32'h34};
        v[9]  = '{1'b1, 5'd14, 32'h200,       5'd12, 32'h0,   5'b10000, 1'b1, 32'h200, 32'h1000_0000};
        v[10] = '{1'b0, 5'd0,  32'h0,         5'd14, 32'h0,   5'b00000, 1'b0, 32'h0,   32'h200};
        v[11] = '{1'b0, 5'd0,  32'h0,         5'd12, 32'h500, 5'b00111, 1'b1, 32'h40,  32'h1000_0000};
        v[12] = '{1'b0, 5'd0,  32'h0,         5'd13, 32'h600, 5'b01110, 1'b1, 32'h40,  32'h20};
        v[13] = '{1'b0, 5'd0,  32'h0,         5'd13, 32'h0,   5'b10000, 1'b1, 32'h500, 32'h28};
        v[14] = '{1'b0, 5'd0,  32'h0,         5'd12, 32'h0,   5'b00000, 1'b0, 32'h0,   32'h1000_0000};
        v[15] = '{1'b0, 5'd0,  32'h0,         5'd3,  32'h0,   5'b00000, 1'b0, 32'h0,   32'h0};
        v[16] = '{1'b0, 5'd0,  32'h0,         5'd15, 32'h0,   5'b00000, 1'b0, 32'h0,   32'h1};
        v[17] = '{1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0,   5'b00000, 1'b0, 32'h0,   32'hFFFF_FFFF};
        v[18] = '{1'b0, 5'd0,  32'h0,         5'd13, 32'h0,   5'b00000, 1'b0, 32'h0,   32'h328};
        v[19] = '{1'b1, 5'd13, 32'h0,         5'd13, 32'h0,   5'b00000, 1'b0, 32'h0,   32'h0};

        // reset state
        #1 rst = 1'b1;
        cp0rAddr = 5'd12;
        #2;
        check("rst_status_rd", cp0rData, 32'h1000_0000);
        check("rst_excpt", {31'd0, excpt_o}, 32'd0);
        check("rst_intimer", {31'd0, intimer_o}, 32'd0);
        check("rst_cause", cause_o, 32'd0);
        check("rst_epc", epc_o, 32'd0);
        check("rst_count4", u1_count, 32'd0);
        #9 rst = 1'b0;

        // Count rate for COUNT_DIV 1 and 4
        tick();
        cp0rAddr = 5'd9;
        #2;
        check("count1_t1", cp0rData, 32'd1);
        check("count4_t1", u1_count, 32'd0);
        tick(); #2;
        check("count1_t2", cp0rData, 32'd2);
        check("count4_t2", u1_count, 32'd0);
        repeat (2) tick();
        #2;
        check("count1_t4", cp0rData, 32'd4);
        check("count4_t4", u1_count, 32'd1);
        repeat (4) tick();
        #2;
        check("count1_t8", cp0rData, 32'd8);
        check("count4_t8", u1_count, 32'd2);

        for (int i = 0; i < 20; i++) begin
            tick();
            cp0we = v[i].we;
            cp0wAddr = v[i].wa;
            cp0wData = v[i].wd;
            cp0rAddr = v[i].ra;
            pc_i = v[i].pc;
            excptype_i = {19'd0, v[i].et, 8'd0};
            #2;
            check($sformatf("vec%0d_excpt", i), {31'd0, excpt_o}, {31'd0, v[i].x_excpt});
            check($sformatf("vec%0d_ejpc", i), ejpc_o, v[i].x_ejpc);
            check($sformatf("vec%0d_rd", i), cp0rData, v[i].x_rd);
        end

        // interrupt beats ovf; no interrupt while EXL=1; taken right after ERET
        tick();
        cp0we = 1'b1; cp0wAddr = 5'd12; cp0wData = 32'h1000_0401;
        int_i = 6'b000001; excptype_i = '0; pc_i = '0;
        tick();
        cp0we = 1'b0; excptype_i = 32'h0000_0400; pc_i = 32'h700;
        #2;
        check("int_vs_ovf_excpt", {31'd0, excpt_o}, 32'd1);
        check("int_vs_ovf_ejpc", ejpc_o, 32'h40);
        tick();
        excptype_i = '0;
        #2;
        check("int_exccode", {27'd0, cause_o[6:2]}, 32'd0);
        check("int_epc", epc_o, 32'h700);
        check("int_status", status_o, 32'h1000_0403);
        check("exl_block1", {31'd0, excpt_o}, 32'd0);
        tick(); #2;
        check("exl_block2", {31'd0, excpt_o}, 32'd0);
        tick();
        excptype_i = 32'h0000_1000;
        #2;
        check("eret_excpt", {31'd0, excpt_o}, 32'd1);
        check("eret_ejpc", ejpc_o, 32'h700);
        tick();
        excptype_i = '0; pc_i = 32'hA00;
        #2;
        check("int_after_eret", {31'd0, excpt_o}, 32'd1);
        check("int_after_eret_ejpc", ejpc_o, 32'h40);
        tick();
        int_i = '0; cp0we = 1'b1; cp0wAddr = 5'd12; cp0wData = 32'h0;
        #2;
        check("int2_none", {31'd0, excpt_o}, 32'd0);
        check("int2_epc", epc_o, 32'hA00);

        // timer interrupt via Compare
        tick();
        cp0wAddr = 5'd9; cp0wData = 32'd0;
        tick();
        cp0wAddr = 5'd11; cp0wData = 32'd5;
        tick();
        cp0wAddr = 5'd12; cp0wData = 32'h1000_8001;
        tick();
        cp0we = 1'b0; cp0rAddr = 5'd9; pc_i = 32'h800;
        #2;
        check("timer_count2", cp0rData, 32'd2);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(); #2;
            found = intimer_o;
        end
        check("timer_rise", {31'd0, found}, 32'd1);
        check("timer_count_at_rise", cp0rData, 32'd6);
        check("timer_no_int_yet", {31'd0, excpt_o}, 32'd0);
        tick(); #2;
        check("timer_int_excpt", {31'd0, excpt_o}, 32'd1);
        check("timer_int_ejpc", ejpc_o, 32'h40);
        tick();
        cp0we = 1'b1; cp0wAddr = 5'd11; cp0wData = 32'd100;
        #2;
        check("timer_epc", epc_o, 32'h800);
        check("timer_status", status_o, 32'h1000_8003);
        check("timer_cause", cause_o, 32'h0000_8000);
        tick();
        cp0wAddr = 5'd12; cp0wData = 32'h0;
        #2;
        check("timer_clear", {31'd0, intimer_o}, 32'd0);

        // Count wrap, then async reset mid-exception
        tick();
        cp0wAddr = 5'd9; cp0wData = 32'hFFFF_FFFF;
        #2;
        check("count_wr_bypass", cp0rData, 32'hFFFF_FFFF);
        tick();
        cp0we = 1'b0;
        #2;
        check("count_max", cp0rData, 32'hFFFF_FFFF);
        tick(); #2;
        check("count_wrap", cp0rData, 32'd0);
        tick();
        excptype_i = 32'h0000_0100; pc_i = 32'h900;
        #2;
        check("sys_excpt", {31'd0, excpt_o}, 32'd1);
        tick(); #2;
        check("sys_epc", epc_o, 32'h900);
        check("sys_status", status_o, 32'h1000_0002);
        check("sys_count", cp0rData, 32'd2);
        #1 rst = 1'b1;
        #1;
        check("arst_excpt", {31'd0, excpt_o}, 32'd0);
        check("arst_ejpc", ejpc_o, 32'd0);
        check("arst_status", status_o, 32'h1000_0000);
        check("arst_epc", epc_o, 32'd0);
        check("arst_count", cp0rData, 32'd0);
        excptype_i = '0;
        #7 rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
